lcm_arbiter: RTL

Round-robin scheduler that shares one iterative LCM engine among `NREQ` requesters. It latches the winning requester's operand pair, starts the engine and waits for its done. It then returns the result, tagged with the requester index, and acknowledges that requester. Zero operands and engine hangs never reach or wedge the engine: they return an error response instead.

---
 rtl/lcm_arbiter_if.sv | 38 +++
 rtl/lcm_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lcm_arbiter_if.sv
// Handshake bundle between the requesters, the round-robin LCM scheduler
// and the shared iterative LCM engine. The scheduler uses the slave
// modport; the environment (requesters plus engine) uses the master modport.
interface lcm_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 32,
    parameter int IDW  = $clog2(NREQ)
);
    // Requester side
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] n1;
    logic [NREQ*W-1:0] n2;
    logic [NREQ-1:0]   ack;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      result;
    logic              err;

    // Engine side
    logic              core_start;
    logic              core_abort;
    logic [W-1:0]      core_n1;
    logic [W-1:0]      core_n2;
    logic              core_done;
    logic [W-1:0]      core_result;

    modport slave (
        input  req, n1, n2, core_done, core_result,
        output ack, resp_valid, resp_id, result, err,
               core_start, core_abort, core_n1, core_n2
    );

    modport master (
        output req, n1, n2, core_done, core_result,
        input  ack, resp_valid, resp_id, result, err,
               core_start, core_abort, core_n1, core_n2
    );
endinterface

// File: rtl/lcm_arbiter.sv
// Round-robin scheduler sharing one iterative LCM engine among NREQ
// requesters. A grant latches the winner's operands, starts the engine and
// waits for done; zero operands and engine hangs are answered with an error
// response so they can never reach or wedge the engine.
module lcm_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    lcm_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_next;

    // Round-robin pointer and scan result
    logic [IDW-1:0] last;
    logic [IDW-1:0] win;
    logic           found;
    logic [W-1:0]   win_n1;
    logic [W-1:0]   win_n2;

    // Held response and engine operand registers
    logic [IDW-1:0] resp_id_q;
    logic [W-1:0]   result_q;
    logic           err_q;
    logic [W-1:0]   core_n1_q;
    logic [W-1:0]   core_n2_q;
    logic [CW-1:0]  cnt;

    // Strobes from the FSM into the datapath
    logic           load_grant;
    logic           load_zero;
    logic           load_done;
    logic           load_abort;
    logic           cnt_clr;
    logic           cnt_inc;
    logic           core_start;
    logic           core_abort;
    logic           resp_valid;
    logic [NREQ-1:0] ack_vec;

    // Scan req starting just after the last winner; first set bit wins
    always_comb begin : rr_scan
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
        win_n1 = bus.n1[int'(win)*W +: W];
        win_n2 = bus.n2[int'(win)*W +: W];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        state_next = state;
        load_grant = 1'b0;
        load_zero  = 1'b0;
        load_done  = 1'b0;
        load_abort = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        core_start = 1'b0;
        core_abort = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load_grant = 1'b1;
                    // A zero operand would never terminate the engine
                    if (win_n1 == '0 || win_n2 == '0) begin
                        load_zero  = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                cnt_clr    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // done on the last allowed cycle still counts as success
                if (bus.core_done) begin
                    load_done  = 1'b1;
                    state_next = RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    core_abort = 1'b1;
                    load_abort = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping, engine operands, response capture and timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= IDW'(NREQ - 1);
            resp_id_q <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            core_n1_q <= '0;
            core_n2_q <= '0;
            cnt       <= '0;
        end else begin
            if (load_grant) begin
                core_n1_q <= win_n1;
                core_n2_q <= win_n2;
                resp_id_q <= win;
                last      <= win;
            end
            if (load_zero || load_abort) begin
                err_q    <= 1'b1;
                result_q <= '0;
            end
            if (load_done) begin
                err_q    <= 1'b0;
                result_q <= bus.core_result;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // One-hot acknowledge to the requester being answered
    always_comb begin
        ack_vec = '0;
        if (state == RESP) begin
            ack_vec[resp_id_q] = 1'b1;
        end
    end

    assign bus.ack        = ack_vec;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_id    = resp_id_q;
    assign bus.result     = result_q;
    assign bus.err        = err_q;
    assign bus.core_start = core_start;
    assign bus.core_abort = core_abort;
    assign bus.core_n1    = core_n1_q;
    assign bus.core_n2    = core_n2_q;
endmodule
